// File: rtl/lfsr_stream.sv
// Leap-forward XNOR LFSR on a valid/ready stream. It reseeds at runtime, replaces a
// lockup seed with all-ones, runs an optional warm-up after every load and counts beats.
module lfsr_stream #(
   parameter int unsigned      WIDTH        = 16,
   parameter logic [WIDTH-1:0] POLYNOMIAL   = 16'h8016,
   parameter int unsigned      OUT_WIDTH    = 1,
   parameter logic [WIDTH-1:0] RESET_SEED   = WIDTH'(1),
   parameter int unsigned      WARMUP_BEATS = 0,
   parameter int unsigned      COUNT_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       seed,
   input  logic                   seed_valid,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   seed_fixed,
   output logic [COUNT_WIDTH-1:0] beat_count
);

   if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
      $error("lfsr_stream: WIDTH must be in 4..64");
   end
   if (POLYNOMIAL == '0) begin : g_bad_poly
      $error("lfsr_stream: POLYNOMIAL must not be zero");
   end
   if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_bad_out
      $error("lfsr_stream: OUT_WIDTH must be in 1..WIDTH");
   end
   if (WARMUP_BEATS > 255) begin : g_bad_warm
      $error("lfsr_stream: WARMUP_BEATS must be in 0..255");
   end

   // An XNOR chain over an even number of taps maps all-zeros onto itself.
   localparam bit               HAS_LOCKUP  = ($countones(POLYNOMIAL) % 2) == 0;
   localparam bit               RESET_LOCK  = HAS_LOCKUP && (RESET_SEED == '0);
   localparam logic [WIDTH-1:0] RESET_STATE = RESET_LOCK ? '1 : RESET_SEED;
   localparam logic [7:0]       WARM_LOAD   = 8'(WARMUP_BEATS);

   typedef enum logic {
      WARMUP,
      RUN
   } fsm_t;

   fsm_t                   fsm_state, fsm_next;
   logic [WIDTH-1:0]       lfsr, lfsr_next, lfsr_beat;
   logic [7:0]             warm_cnt, warm_next;
   logic [COUNT_WIDTH-1:0] count_next;
   logic                   fixed_next;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
      logic acc;
      acc = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (POLYNOMIAL[i]) acc = ~(acc ^ s[i]);
      end
      return {s[WIDTH-2:0], acc};
   endfunction

   function automatic logic [WIDTH-1:0] beat(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      r = s;
      for (int unsigned i = 0; i < OUT_WIDTH; i++) r = step(r);
      return r;
   endfunction

   assign lfsr_beat = beat(lfsr);
   assign out_data  = lfsr[OUT_WIDTH-1:0];

   always_comb begin
      fsm_next   = fsm_state;
      lfsr_next  = lfsr;
      warm_next  = warm_cnt;
      count_next = beat_count;
      fixed_next = seed_fixed;
      out_valid  = 1'b0;
      unique case (fsm_state)
         WARMUP: begin
            lfsr_next = lfsr_beat;
            warm_next = warm_cnt - 8'd1;
            if (warm_cnt <= 8'd1) fsm_next = RUN;
         end
         RUN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               lfsr_next  = lfsr_beat;
               count_next = beat_count + COUNT_WIDTH'(1);
            end
         end
         default: fsm_next = RUN;
      endcase
      // A seed load overrides whatever the FSM decided, including a concurrent handshake.
      if (seed_valid) begin
         fixed_next = HAS_LOCKUP && (seed == '0);
         lfsr_next  = fixed_next ? '1 : seed;
         count_next = '0;
         warm_next  = WARM_LOAD;
         fsm_next   = (WARMUP_BEATS > 0) ? WARMUP : RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr       <= RESET_STATE;
         seed_fixed <= RESET_LOCK;
         beat_count <= '0;
         warm_cnt   <= WARM_LOAD;
         fsm_state  <= (WARMUP_BEATS > 0) ? WARMUP : RUN;
      end else begin
         lfsr       <= lfsr_next;
         seed_fixed <= fixed_next;
         beat_count <= count_next;
         warm_cnt   <= warm_next;
         fsm_state  <= fsm_next;
      end
   end

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboarded bench for lfsr_stream across several parameter sets with directed,
// hand-derived expected sequences.
module tb_lfsr_stream;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // A: W4 poly 9 single-step, 4-bit beat counter
   logic [3:0] seed_a;  logic sv_a, ready_a, data_a, valid_a, fixed_a;  logic [3:0] count_a;
   // B: W4 poly 9 leap-forward by 4
   logic [3:0] seed_b;  logic sv_b, ready_b, valid_b, fixed_b;  logic [3:0] data_b;  logic [31:0] count_b;
   // C: W16 default polynomial, 8-bit words
   logic [15:0] seed_c; logic sv_c, ready_c, valid_c, fixed_c;  logic [7:0] data_c;  logic [31:0] count_c;
   // D: W4 poly 9 leap 4 with 3 warm-up beats
   logic [3:0] seed_d;  logic sv_d, ready_d, valid_d, fixed_d;  logic [3:0] data_d;  logic [31:0] count_d;
   // E (2 taps, reset seed 0) and F (3 taps), both W5
   logic [4:0] seed_ef; logic sv_ef, ready_ef;
   logic [4:0] data_e, data_f;  logic valid_e, valid_f, fixed_e, fixed_f;  logic [31:0] count_e, count_f;

   lfsr_stream #(.WIDTH(4), .POLYNOMIAL(4'h9), .OUT_WIDTH(1), .RESET_SEED(4'h1),
                 .WARMUP_BEATS(0), .COUNT_WIDTH(4)) u_a (
      .clk(clk), .reset(reset), .seed(seed_a), .seed_valid(sv_a), .out_data(data_a),
      .out_valid(valid_a), .out_ready(ready_a), .seed_fixed(fixed_a), .beat_count(count_a));

   lfsr_stream #(.WIDTH(4), .POLYNOMIAL(4'h9), .OUT_WIDTH(4), .RESET_SEED(4'h1)) u_b (
      .clk(clk), .reset(reset), .seed(seed_b), .seed_valid(sv_b), .out_data(data_b),
      .out_valid(valid_b), .out_ready(ready_b), .seed_fixed(fixed_b), .beat_count(count_b));

   lfsr_stream #(.WIDTH(16), .POLYNOMIAL(16'h8016), .OUT_WIDTH(8)) u_c (
      .clk(clk), .reset(reset), .seed(seed_c), .seed_valid(sv_c), .out_data(data_c),
      .out_valid(valid_c), .out_ready(ready_c), .seed_fixed(fixed_c), .beat_count(count_c));

   lfsr_stream #(.WIDTH(4), .POLYNOMIAL(4'h9), .OUT_WIDTH(4), .RESET_SEED(4'h1),
                 .WARMUP_BEATS(3)) u_d (
      .clk(clk), .reset(reset), .seed(seed_d), .seed_valid(sv_d), .out_data(data_d),
      .out_valid(valid_d), .out_ready(ready_d), .seed_fixed(fixed_d), .beat_count(count_d));

   lfsr_stream #(.WIDTH(5), .POLYNOMIAL(5'h12), .OUT_WIDTH(5), .RESET_SEED(5'h00)) u_e (
      .clk(clk), .reset(reset), .seed(seed_ef), .seed_valid(sv_ef), .out_data(data_e),
      .out_valid(valid_e), .out_ready(ready_ef), .seed_fixed(fixed_e), .beat_count(count_e));

   lfsr_stream #(.WIDTH(5), .POLYNOMIAL(5'h13), .OUT_WIDTH(5), .RESET_SEED(5'h01)) u_f (
      .clk(clk), .reset(reset), .seed(seed_ef), .seed_valid(sv_ef), .out_data(data_f),
      .out_valid(valid_f), .out_ready(ready_ef), .seed_fixed(fixed_f), .beat_count(count_f));

   logic [7:0] qa[$], qb[$], qc[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference for C: XNOR chain == parity of taps, inverted for an odd tap count.
   localparam logic [15:0] POLY_C = 16'h8016;
   localparam bit          ODD_C  = ($countones(POLY_C) % 2) != 0;
   function automatic logic [15:0] model_beat(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int k = 0; k < 8; k++) r = {r[14:0], (^(r & POLY_C)) ^ ODD_C};
      return r;
   endfunction

   // Monitor: a handshake that is not overridden by reset or a seed load consumes one word.
   always @(negedge clk) begin
      if (!reset) begin
         if (valid_a && ready_a && !sv_a) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_word: got 0x%0h, expected no handshake", data_a);
            end else check("a_word", 64'(data_a), 64'(qa.pop_front()));
         end
         if (valid_b && ready_b && !sv_b) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_word: got 0x%0h, expected no handshake", data_b);
            end else check("b_word", 64'(data_b), 64'(qb.pop_front()));
         end
         if (valid_c && ready_c && !sv_c) begin
            if (qc.size() == 0) begin
               checks++; errors++;
               $display("FAIL c_word: got 0x%0h, expected no handshake", data_c);
            end else check("c_word", 64'(data_c), 64'(qc.pop_front()));
         end
      end
   end

   logic [3:0]  seq_a[15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
   logic [31:0] pat_c = 32'b1011_0011_1000_1101_0110_0101_1100_1011;
   logic [15:0] m_c;
   int          n_c;

   initial begin
      reset = 1'b1;
      seed_a = '0; sv_a = 1'b0; ready_a = 1'b0;
      seed_b = '0; sv_b = 1'b0; ready_b = 1'b0;
      seed_c = '0; sv_c = 1'b0; ready_c = 1'b0;
      seed_d = '0; sv_d = 1'b0; ready_d = 1'b0;
      seed_ef = '0; sv_ef = 1'b0; ready_ef = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // reset state
      check("a_rst_data", 64'(data_a), 64'h1);
      check("a_rst_valid", 64'(valid_a), 64'h1);
      check("a_rst_count", 64'(count_a), 64'h0);
      check("b_rst_data", 64'(data_b), 64'h1);
      check("c_rst_data", 64'(data_c), 64'h01);
      check("d_rst_valid", 64'(valid_d), 64'h0);
      check("e_rst_data", 64'(data_e), 64'h1F);
      check("e_rst_fixed", 64'(fixed_e), 64'h1);
      check("f_rst_data", 64'(data_f), 64'h01);
      check("f_rst_fixed", 64'(fixed_f), 64'h0);

      // single-step period of 15, then 4-bit count wraps
      foreach (seq_a[i]) qa.push_back(8'(seq_a[i][0]));
      ready_a = 1'b1;
      repeat (15) tick();
      ready_a = 1'b0;
      check("a_count15", 64'(count_a), 64'hF);
      check("a_period_data", 64'(data_a), 64'h1);
      qa.push_back(8'h1);
      ready_a = 1'b1; tick(); ready_a = 1'b0;
      check("a_count_wrap", 64'(count_a), 64'h0);

      // leap-forward, lockup correction, seed/handshake priority, hold
      seed_b = 4'h5; sv_b = 1'b1; tick(); sv_b = 1'b0;
      check("b_seed_data", 64'(data_b), 64'h5);
      check("b_seed_fixed", 64'(fixed_b), 64'h0);
      qb.push_back(8'h5); qb.push_back(8'h9);
      ready_b = 1'b1; tick(); tick(); ready_b = 1'b0;
      check("b_leap_data", 64'(data_b), 64'h1);
      check("b_leap_count", 64'(count_b), 64'h2);
      seed_b = 4'h0; sv_b = 1'b1; ready_b = 1'b1; tick(); sv_b = 1'b0; ready_b = 1'b0;
      check("b_lock_data", 64'(data_b), 64'hF);
      check("b_lock_fixed", 64'(fixed_b), 64'h1);
      check("b_prio_count", 64'(count_b), 64'h0);
      tick(); tick();
      check("b_hold_data", 64'(data_b), 64'hF);
      seed_b = 4'h3; sv_b = 1'b1; tick(); sv_b = 1'b0;
      check("b_unlock_fixed", 64'(fixed_b), 64'h0);
      check("b_unlock_data", 64'(data_b), 64'h3);

      // 16-bit backpressure against the reference model
      qc.push_back(8'h01);
      ready_c = 1'b1; tick(); ready_c = 1'b0;
      check("c_first_leap", 64'(data_c), 64'h7A);
      m_c = 16'h017A; n_c = 1;
      for (int i = 0; i < 32; i++) begin
         ready_c = pat_c[i];
         if (pat_c[i]) begin
            qc.push_back(m_c[7:0]);
            m_c = model_beat(m_c);
            n_c++;
         end
         tick();
         check("c_state", 64'(data_c), 64'(m_c[7:0]));
      end
      ready_c = 1'b0;
      check("c_count", 64'(count_c), 64'(n_c));

      // warm-up of 3 beats, then a reload two cycles in restarts it
      seed_d = 4'h1; sv_d = 1'b1; tick(); sv_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("d_warm_valid", 64'(valid_d), 64'h0);
         tick();
      end
      check("d_run_valid", 64'(valid_d), 64'h1);
      check("d_run_data", 64'(data_d), 64'h2);
      seed_d = 4'h1; sv_d = 1'b1; tick(); sv_d = 1'b0;
      tick();
      seed_d = 4'h5; sv_d = 1'b1; tick(); sv_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("d_rewarm_valid", 64'(valid_d), 64'h0);
         tick();
      end
      check("d_rerun_valid", 64'(valid_d), 64'h1);
      check("d_rerun_data", 64'(data_d), 64'hE);

      // lockup depends on tap parity
      seed_ef = 5'h00; sv_ef = 1'b1; tick(); sv_ef = 1'b0;
      check("e_lock_data", 64'(data_e), 64'h1F);
      check("e_lock_fixed", 64'(fixed_e), 64'h1);
      check("f_zero_data", 64'(data_f), 64'h00);
      check("f_zero_fixed", 64'(fixed_f), 64'h0);
      seed_ef = 5'h03; sv_ef = 1'b1; tick(); sv_ef = 1'b0;
      check("e_unlock_fixed", 64'(fixed_e), 64'h0);
      check("e_unlock_data", 64'(data_e), 64'h03);

      // reset outranks a simultaneous seed load
      reset = 1'b1;
      seed_a = 4'h0; sv_a = 1'b1;
      seed_b = 4'h6; sv_b = 1'b1;
      tick();
      reset = 1'b0; sv_a = 1'b0; sv_b = 1'b0;
      check("a_rprio_fixed", 64'(fixed_a), 64'h0);
      check("a_rprio_data", 64'(data_a), 64'h1);
      check("b_rprio_data", 64'(data_b), 64'h1);
      check("b_rprio_count", 64'(count_b), 64'h0);
      check("d_rprio_valid", 64'(valid_d), 64'h0);

      tick();
      check("qa_drained", 64'(qa.size()), 64'h0);
      check("qb_drained", 64'(qb.size()), 64'h0);
      check("qc_drained", 64'(qc.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
- Parametrised successor to the team's single-step XNOR LFSR generator.
- Emits OUT_WIDTH-bit pseudo-random words on a valid/ready stream. Each accepted word advances the LFSR by OUT_WIDTH steps in one cycle (leap-forward).
- Adds a runtime reseed port with lockup-seed correction, a post-seed warm-up phase and a beat counter.
- Sits between seed/config logic and random-data consumers such as test-pattern generators and dither.

Parameters:
- WIDTH, 16: LFSR state width; legal range 4..64.
- POLYNOMIAL, 16'h8016: feedback tap mask; bit i set means state[i] is a tap. Zero is an elaboration error.
- OUT_WIDTH, 1: bits per output word; 1 <= OUT_WIDTH <= WIDTH, otherwise elaboration error.
- RESET_SEED, WIDTH'(1): state loaded on reset. Corrected like any other seed.
- WARMUP_BEATS, 0: number of silent beats after every seed load; 0..255.
- COUNT_WIDTH, 32: width of beat_count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- seed  input  WIDTH  new seed value.
- seed_valid  input  1  load seed this cycle. No ready signal; loads are always accepted.
- out_data  output  OUT_WIDTH  current word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word.
- seed_fixed  output  1  last loaded seed was the lockup state and was replaced.
- beat_count  output  COUNT_WIDTH  number of words accepted since the last reset or seed load.

Behaviour:
- Single step: fb is computed as acc=0, then for each i ascending with POLYNOMIAL[i]=1, acc = ~(acc ^ state[i]); fb = final acc. Next state = {state[WIDTH-2:0], fb}.
- Beat: OUT_WIDTH chained single steps, computed combinationally and applied in one clock.
- out_data = state[OUT_WIDTH-1:0], registered state only, no combinational path from out_ready.
- Lockup state L: all-zeros if popcount(POLYNOMIAL) is even; no lockup state if the count is odd. A loaded value equal to L is replaced by all-ones and sets seed_fixed=1; any other load clears seed_fixed.
- FSM states:
  - WARMUP: out_valid=0; advance one beat per cycle; decrement warm counter; when the counter reaches 0, go to RUN in the same cycle the last warm-up beat is applied.
  - RUN: out_valid=1; advance one beat and increment beat_count only on out_valid && out_ready; otherwise hold state and out_data stable.
- Reset (highest priority): state <= corrected RESET_SEED; seed_fixed per correction; beat_count <= 0; FSM goes to WARMUP with counter=WARMUP_BEATS if WARMUP_BEATS>0, otherwise to RUN. All outputs reflect this from the cycle after reset. out_valid=0 in the cycle following reset only when WARMUP_BEATS>0.
- seed_valid (second priority, any state): behaves exactly as the reset load but uses the seed port. A handshake in the same cycle is discarded: no advance, no count. Mid-warm-up reload restarts the warm-up count.
- beat_count wraps modulo 2^COUNT_WIDTH.
- No X on any output after the first reset. Behaviour before the first reset is undefined.

Test Plan:
- Single-step sequence: WIDTH=4, POLYNOMIAL=4'h9, OUT_WIDTH=1, RESET_SEED=1, out_ready=1 after reset -> out_data LSBs follow state 0x1,0x3,0x7,0xF,0xE,0xD,0xA,0x5,0xB. State returns to 0x1 after exactly 15 beats; beat_count=15.
- Leap-forward: same config with OUT_WIDTH=4, seed 0x5 loaded -> first word 0x5, next word 0x9 (four single steps in one clock).
- Backpressure: WIDTH=16 default, out_ready toggled randomly -> out_data is held whenever out_ready=0; the accepted word stream equals the out_ready=1 stream; beat_count equals the number of handshakes.
- Lockup seed: POLYNOMIAL=4'h9 (even taps), seed 0x0 loaded -> state 0xF, seed_fixed=1. Then seed 0x3 -> seed_fixed=0. With POLYNOMIAL=5'h12 (2 taps) the same applies; with 3 taps, seed 0 loads as 0 and seed_fixed=0.
- Warm-up: WARMUP_BEATS=3 -> out_valid stays 0 for 3 cycles after reset; the first word equals the 4th state from the seed. A reseed at warm-up cycle 2 restarts the 3-cycle warm-up.
- Priority: seed_valid together with an out handshake -> seed loaded, beat_count=0, no advance. reset together with seed_valid -> RESET_SEED loaded.
